single_cycle_cpu: RTL and testbench
===================================

// Module: single_cycle_cpu
// PURPOSE
//  Single-cycle 32-bit MIPS-subset processor (top-level DUT "cpu") with internal instruction memory,
//  register file, ALU and data memory. A program is loaded word-by-word through the initialize port,
//  then executes one instruction per clk rising edge. There are no functional outputs; state is
//  observed hierarchically through pc, regfile[0:31] and dmem[0:63].
// PARAMETERS
//  IMEM_WORDS  64  instruction memory depth (32-bit words)
//  DMEM_WORDS  64  data memory depth (32-bit words)
// PORTS
//  clk                             in  1   system clock, rising-edge active
//  rst                             in  1   asynchronous, active-low reset (rst=0 resets)
//  initialize                      in  1   1 = program-load mode, 0 = run
//  instruction_initialize_data     in  32  instruction word to load
//  instruction_initialize_address  in  32  byte address of load (word-aligned; bits [7:2] index imem)
// BEHAVIOUR
//  - Reset (rst=0, async): pc=0; regfile[i]=i for i=0..31; dmem all 0. imem is NOT reset.
//  - Load: on each clk edge while initialize=1, imem[addr[7:2]] <= data. Load works during reset.
//    While initialize=1, pc is held at 0 and there are no regfile/dmem writes.
//  - Run (initialize=0, rst=1): each clk edge retires the instruction at imem[pc[7:2]]. Reads are
//    combinational; regfile, dmem and pc update on the same edge.
//  - R0 reads 0 always; writes to R0 are discarded.
//  - R-type (op 000000, rd<=rs OP rt), funct: ADD 20h, SUB 22h, AND 24h, OR 25h, XOR 26h,
//    NOR 27h, SLT 2Ah (signed compare, result 1/0). shamt ignored. ADD/SUB wrap with no trap.
//  - ADDI 08h: rt<=rs+sext(imm). ORI 0Dh: rt<=rs|zext(imm). LUI 0Fh: rt<={imm,16'h0}.
//  - LW 23h: rt<=dmem[(rs+sext(imm))[7:2]]. SW 2Bh: dmem[same]<=rt. Address wraps mod 256 bytes.
//  - BEQ 04h / BNE 05h: if taken (rs==rt / rs!=rt), pc<=pc+4+(sext(imm)<<2), else pc<=pc+4.
//  - J 02h: pc<={pc_plus4[31:28],target26,2'b00}.
//  - Any other opcode or funct is a NOP: pc<=pc+4, no writes.
//  - pc increments past imem end wrap via the [7:2] index; unloaded words read as 0, which
//    executes as a NOP (SLL encoding is not supported).
//  - Reset asserted mid-run takes effect immediately and takes priority over all edge actions.
//  - Self-loop "BEQ R0,R0,-1" is the halt idiom: pc stays constant and the program makes no
//    further state change.
// TESTING
//  Load the program below at byte addresses 0,4,...,68 with initialize=1, rst=0->1, then set
//  initialize=0 and run.
//  1 ALU R-type from reset values: ADD R1,R0,R2 -> R1=2; SUB R8,R4,R4 -> R8=0; OR R7,R5,R6 -> R7=7;
//    AND R6,R0,R1 -> R6=0.
//  2 Memory: SW R9,12(R0) -> dmem[3]=9; next LW R12,12(R0) -> R12=9.
//  3 Immediates: ADDI R15,R14,4 -> 18; ORI R16,R17,FFFFh -> 0000FFFFh (zero-ext);
//    LUI R18,1 -> 00010000h.
//  4 Jump at 36 with target 11 -> pc=44; ADD at 40 skipped (R1 stays 2). NOR R6,R7,R5 -> FFFFFFF8h;
//    XOR R4,R2,R3 -> 1; SLT R4,R2,R3 -> 1.
//  5 Branch: BNE R1,R0,+1 at 56 -> pc=64 (60 skipped); BEQ R0,R0,-1 at 68 -> pc stays 68 for
//    >=10 cycles with no reg/mem changes.
//  6 Reset/NOP: pull rst low mid-run -> pc=0 and regs=index immediately, before the next clk edge;
//    imem intact and the rerun reproduces identical results. A word with op 3Fh executes as pc+4 only.

Source files
------------

// File: rtl/single_cycle_cpu.sv
// Single-cycle 32-bit MIPS-subset processor with internal imem, regfile, ALU and dmem.
// Ports:
//   clk                            - rising-edge clock
//   rst                            - async active-low reset (pc, regfile, dmem; not imem)
//   initialize                     - 1 = load imem word per edge and hold pc at 0, 0 = run
//   instruction_initialize_data    - instruction word to load
//   instruction_initialize_address - byte address of the load (word index in [7:2])
// Architectural state is observed hierarchically through pc, regfile and dmem.
module single_cycle_cpu #(
  parameter int unsigned IMEM_WORDS = 64,
  parameter int unsigned DMEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        initialize,
  input  logic [31:0] instruction_initialize_data,
  input  logic [31:0] instruction_initialize_address
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned IW   = $clog2(IMEM_WORDS);
  localparam int unsigned DW   = $clog2(DMEM_WORDS);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  logic [XLEN-1:0] imem    [IMEM_WORDS];
  logic [XLEN-1:0] regfile [32];
  logic [XLEN-1:0] dmem    [DMEM_WORDS];
  logic [XLEN-1:0] pc;

  logic [XLEN-1:0] instr, rs_val, rt_val, imm_sext, imm_zext, pc_plus4, pc_d;
  logic [XLEN-1:0] mem_sum, rf_wd;
  logic [5:0]      op, funct;
  logic [4:0]      rs, rt, rd, rf_wa;
  logic            rf_we, mem_we;
  logic [DW-1:0]   mem_idx;
  logic            unused_bits;

  // Address bits outside the word index are intentionally ignored.
  assign unused_bits = ^{instruction_initialize_address, mem_sum};

  // Program load port; imem has no reset so a loaded program survives rst.
  always_ff @(posedge clk) begin
    if (initialize) begin
      imem[instruction_initialize_address[IW+1:2]] <= instruction_initialize_data;
    end
  end

  // Decode, ALU and next-pc.
  always_comb begin
    instr    = imem[pc[IW+1:2]];
    op       = instr[31:26];
    rs       = instr[25:21];
    rt       = instr[20:16];
    rd       = instr[15:11];
    funct    = instr[5:0];
    rs_val   = (rs == 5'd0) ? '0 : regfile[rs];
    rt_val   = (rt == 5'd0) ? '0 : regfile[rt];
    imm_sext = {{16{instr[15]}}, instr[15:0]};
    imm_zext = {16'h0000, instr[15:0]};
    pc_plus4 = pc + 32'd4;
    mem_sum  = rs_val + imm_sext;
    mem_idx  = mem_sum[DW+1:2];
    pc_d     = pc_plus4;
    rf_we    = 1'b0;
    rf_wa    = rt;
    rf_wd    = '0;
    mem_we   = 1'b0;
    case (op)
      OP_RTYPE: begin
        rf_wa = rd;
        rf_we = 1'b1;
        case (funct)
          FN_ADD:  rf_wd = rs_val + rt_val;
          FN_SUB:  rf_wd = rs_val - rt_val;
          FN_AND:  rf_wd = rs_val & rt_val;
          FN_OR:   rf_wd = rs_val | rt_val;
          FN_XOR:  rf_wd = rs_val ^ rt_val;
          FN_NOR:  rf_wd = ~(rs_val | rt_val);
          FN_SLT:  rf_wd = ($signed(rs_val) < $signed(rt_val)) ? 32'd1 : 32'd0;
          default: rf_we = 1'b0;
        endcase
      end
      OP_ADDI: begin rf_we = 1'b1; rf_wd = rs_val + imm_sext; end
      OP_ORI:  begin rf_we = 1'b1; rf_wd = rs_val | imm_zext; end
      OP_LUI:  begin rf_we = 1'b1; rf_wd = {instr[15:0], 16'h0000}; end
      OP_LW:   begin rf_we = 1'b1; rf_wd = dmem[mem_idx]; end
      OP_SW:   mem_we = 1'b1;
      OP_BEQ:  if (rs_val == rt_val) pc_d = pc_plus4 + {imm_sext[29:0], 2'b00};
      OP_BNE:  if (rs_val != rt_val) pc_d = pc_plus4 + {imm_sext[29:0], 2'b00};
      OP_J:    pc_d = {pc_plus4[31:28], instr[25:0], 2'b00};
      default: ;
    endcase
  end

  // Architectural state; load mode freezes pc at 0 and blocks all writes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= '0;
      for (int i = 0; i < 32; i++) regfile[i] <= 32'(i);
      for (int i = 0; i < int'(DMEM_WORDS); i++) dmem[i] <= '0;
    end else if (initialize) begin
      pc <= '0;
    end else begin
      pc <= pc_d;
      if (rf_we && (rf_wa != 5'd0)) regfile[rf_wa] <= rf_wd;
      if (mem_we) dmem[mem_idx] <= rt_val;
    end
  end

endmodule

// File: tb/tb_single_cycle_cpu.sv
// Directed bench: loads two small programs, steps them and checks pc/regfile/dmem.
module tb_single_cycle_cpu;

  logic        clk = 1'b0;
  logic        rst;
  logic        initialize;
  logic [31:0] init_data;
  logic [31:0] init_addr;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] exp_rf [32];
  logic [31:0] exp_dm [64];

  single_cycle_cpu dut (
    .clk                            (clk),
    .rst                            (rst),
    .initialize                     (initialize),
    .instruction_initialize_data    (init_data),
    .instruction_initialize_address (init_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  function automatic logic [31:0] r_op(input int rs, input int rt, input int rd, input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_op(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  // Advance n rising edges, leave time at the following falling edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic load_word(input int addr, input logic [31:0] w);
    init_addr = 32'(addr);
    init_data = w;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic exp_reset();
    for (int i = 0; i < 32; i++) exp_rf[i] = 32'(i);
    for (int i = 0; i < 64; i++) exp_dm[i] = 32'd0;
  endtask

  // One comparison over the whole regfile and one over the whole dmem.
  task automatic chk_state(input string tag);
    logic [31:0] bad_rf, bad_dm;
    bad_rf = 0;
    bad_dm = 0;
    for (int i = 0; i < 32; i++) if (dut.regfile[i] !== exp_rf[i]) bad_rf++;
    for (int i = 0; i < 64; i++) if (dut.dmem[i] !== exp_dm[i]) bad_dm++;
    chk({tag, "_rf_bad_count"}, bad_rf, 32'd0);
    chk({tag, "_dm_bad_count"}, bad_dm, 32'd0);
  endtask

  task automatic check_prog1_final(input string tag);
    exp_reset();
    exp_rf[1]  = 32'd2;
    exp_rf[8]  = 32'd0;
    exp_rf[7]  = 32'd7;
    exp_rf[6]  = 32'hFFFF_FFF8;
    exp_rf[12] = 32'd9;
    exp_rf[15] = 32'd18;
    exp_rf[16] = 32'h0000_FFFF;
    exp_rf[18] = 32'h0001_0000;
    exp_rf[4]  = 32'd1;
    exp_dm[3]  = 32'd9;
    chk({tag, "_pc_halt"}, dut.pc, 32'd68);
    chk_state(tag);
  endtask

  logic [31:0] prog1 [18];
  logic [31:0] prog2 [9];

  initial begin
    prog1[0]  = r_op(0, 2, 1, 6'h20);              // ADD R1,R0,R2
    prog1[1]  = r_op(4, 4, 8, 6'h22);              // SUB R8,R4,R4
    prog1[2]  = r_op(5, 6, 7, 6'h25);              // OR  R7,R5,R6
    prog1[3]  = r_op(0, 1, 6, 6'h24);              // AND R6,R0,R1
    prog1[4]  = i_op(6'h2B, 0, 9, 16'd12);         // SW  R9,12(R0)
    prog1[5]  = i_op(6'h23, 0, 12, 16'd12);        // LW  R12,12(R0)
    prog1[6]  = i_op(6'h08, 14, 15, 16'd4);        // ADDI R15,R14,4
    prog1[7]  = i_op(6'h0D, 17, 16, 16'hFFFF);     // ORI R16,R17,FFFF
    prog1[8]  = i_op(6'h0F, 0, 18, 16'd1);         // LUI R18,1
    prog1[9]  = {6'h02, 26'd11};                   // J 11
    prog1[10] = r_op(1, 1, 1, 6'h20);              // ADD R1,R1,R1 (skipped)
    prog1[11] = r_op(7, 5, 6, 6'h27);              // NOR R6,R7,R5
    prog1[12] = r_op(2, 3, 4, 6'h26);              // XOR R4,R2,R3
    prog1[13] = r_op(2, 3, 4, 6'h2A);              // SLT R4,R2,R3
    prog1[14] = i_op(6'h05, 1, 0, 16'd1);          // BNE R1,R0,+1
    prog1[15] = i_op(6'h08, 0, 20, 16'd99);        // ADDI R20,R0,99 (skipped)
    prog1[16] = {6'h3F, 26'h155_5555};             // undefined opcode -> NOP
    prog1[17] = i_op(6'h04, 0, 0, 16'hFFFF);       // BEQ R0,R0,-1

    prog2[0] = r_op(0, 0, 22, 6'h27);              // NOR R22,R0,R0
    prog2[1] = r_op(22, 0, 23, 6'h2A);             // SLT R23,R22,R0 (signed -1<0)
    prog2[2] = r_op(0, 22, 24, 6'h2A);             // SLT R24,R0,R22
    prog2[3] = i_op(6'h08, 0, 25, 16'hFFFF);       // ADDI R25,R0,-1
    prog2[4] = i_op(6'h2B, 0, 1, 16'hFFFC);        // SW  R1,-4(R0) -> wraps to dmem[63]
    prog2[5] = i_op(6'h23, 0, 27, 16'd252);        // LW  R27,252(R0)
    prog2[6] = i_op(6'h08, 0, 0, 16'd5);           // ADDI R0,R0,5 (discarded)
    prog2[7] = i_op(6'h04, 0, 1, 16'd5);           // BEQ R0,R1,+5 (not taken)
    prog2[8] = i_op(6'h04, 0, 0, 16'hFFFF);        // BEQ R0,R0,-1

    rst = 1'b0;
    initialize = 1'b1;
    init_data = '0;
    init_addr = '0;
    @(negedge clk);
    for (int i = 0; i < 18; i++) load_word(4 * i, prog1[i]);
    rst = 1'b1;
    step(1);
    chk("reset_pc", dut.pc, 32'd0);
    chk("reset_r5", dut.regfile[5], 32'd5);
    chk("reset_r31", dut.regfile[31], 32'd31);
    chk("reset_dm3", dut.dmem[3], 32'd0);
    initialize = 1'b0;

    step(1);
    chk("add_r1", dut.regfile[1], 32'd2);
    step(3);
    chk("sub_r8", dut.regfile[8], 32'd0);
    chk("or_r7", dut.regfile[7], 32'd7);
    chk("and_r6", dut.regfile[6], 32'd0);
    step(1);
    chk("sw_dm3", dut.dmem[3], 32'd9);
    step(1);
    chk("lw_r12", dut.regfile[12], 32'd9);
    step(3);
    chk("addi_r15", dut.regfile[15], 32'd18);
    chk("ori_r16", dut.regfile[16], 32'h0000_FFFF);
    chk("lui_r18", dut.regfile[18], 32'h0001_0000);
    step(1);
    chk("j_pc", dut.pc, 32'd44);
    step(1);
    chk("nor_r6", dut.regfile[6], 32'hFFFF_FFF8);
    chk("j_skip_r1", dut.regfile[1], 32'd2);
    step(1);
    chk("xor_r4", dut.regfile[4], 32'd1);
    step(1);
    chk("slt_r4", dut.regfile[4], 32'd1);
    chk("slt_pc", dut.pc, 32'd56);
    step(1);
    chk("bne_pc", dut.pc, 32'd64);
    step(1);
    chk("nop_pc", dut.pc, 32'd68);
    chk("bne_skip_r20", dut.regfile[20], 32'd20);
    step(1);
    chk("halt_pc", dut.pc, 32'd68);
    step(12);
    check_prog1_final("run1");

    // Asynchronous reset away from any clock edge.
    rst = 1'b0;
    #1;
    chk("async_pc", dut.pc, 32'd0);
    chk("async_r1", dut.regfile[1], 32'd1);
    chk("async_r6", dut.regfile[6], 32'd6);
    chk("async_dm3", dut.dmem[3], 32'd0);
    #1;
    rst = 1'b1;
    step(30);
    check_prog1_final("rerun");

    // Second program loaded while held in reset.
    rst = 1'b0;
    initialize = 1'b1;
    for (int i = 0; i < 9; i++) load_word(4 * i, prog2[i]);
    rst = 1'b1;
    step(3);
    chk("init_hold_pc", dut.pc, 32'd0);
    chk("init_hold_r22", dut.regfile[22], 32'd22);
    initialize = 1'b0;
    step(9);
    chk("p2_pc", dut.pc, 32'd32);
    step(12);
    exp_reset();
    exp_rf[22] = 32'hFFFF_FFFF;
    exp_rf[23] = 32'd1;
    exp_rf[24] = 32'd0;
    exp_rf[25] = 32'hFFFF_FFFF;
    exp_rf[27] = 32'd1;
    exp_dm[63] = 32'd1;
    chk("p2_pc_halt", dut.pc, 32'd32);
    chk("p2_r0", dut.regfile[0], 32'd0);
    chk_state("p2");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
